// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: op encoding, FSM states and branch decode helper.
package alu_result_stage_pkg;

  typedef enum logic [3:0] {
    OpAddSub = 4'd0,
    OpSll    = 4'd1,
    OpSlt    = 4'd2,
    OpSltu   = 4'd3,
    OpXor    = 4'd4,
    OpSrlSra = 4'd5,
    OpOr     = 4'd6,
    OpAnd    = 4'd7,
    OpBeq    = 4'd8,
    OpBne    = 4'd9,
    OpBlt    = 4'd10,
    OpBge    = 4'd11,
    OpBltu   = 4'd12,
    OpBgeu   = 4'd13,
    OpIll14  = 4'd14,
    OpIll15  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAlu,
    StWaitCmp,
    StHold
  } state_e;

  function automatic logic op_is_branch(input logic [3:0] op);
    return op[3] & (op < 4'd14);
  endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Combinational result select: picks writeback data, write enable, branch decision and
// illegal flag for one op from the operands and raw ALU outputs.
module alu_result_mux
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned REGINDEX_BITS = 5
) (
  input  logic [3:0]               op,
  input  logic [REGINDEX_BITS-1:0] rd,
  input  logic [31:0]              reg_op1,
  input  logic [31:0]              reg_op2,
  input  logic [31:0]              alu_add_sub,
  input  logic [31:0]              alu_shl,
  input  logic [31:0]              alu_shr,
  input  logic                     alu_eq,
  input  logic                     alu_lts,
  input  logic                     alu_ltu,
  output logic [31:0]              wdata,
  output logic                     wen,
  output logic                     taken,
  output logic                     illegal
);

  logic writes_rd;

  always_comb begin
    wdata     = '0;
    writes_rd = 1'b1;
    taken     = 1'b0;
    illegal   = 1'b0;
    unique case (op_e'(op))
      OpAddSub: wdata = alu_add_sub;
      OpSll:    wdata = alu_shl;
      OpSlt:    wdata = {31'b0, alu_lts};
      OpSltu:   wdata = {31'b0, alu_ltu};
      OpXor:    wdata = reg_op1 ^ reg_op2;
      OpSrlSra: wdata = alu_shr;
      OpOr:     wdata = reg_op1 | reg_op2;
      OpAnd:    wdata = reg_op1 & reg_op2;
      OpBeq:    begin writes_rd = 1'b0; taken = alu_eq;   end
      OpBne:    begin writes_rd = 1'b0; taken = ~alu_eq;  end
      OpBlt:    begin writes_rd = 1'b0; taken = alu_lts;  end
      OpBge:    begin writes_rd = 1'b0; taken = ~alu_lts; end
      OpBltu:   begin writes_rd = 1'b0; taken = alu_ltu;  end
      OpBgeu:   begin writes_rd = 1'b0; taken = ~alu_ltu; end
      default:  begin writes_rd = 1'b0; illegal = 1'b1;   end
    endcase
    // x0 is hardwired to zero, so never request a write to it.
    wen = writes_rd & (rd != '0);
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects and registers the final result per op, resolves branches and
// hands a writeback packet downstream over valid/ready, with optional ALU/compare wait states.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter bit          TWO_CYCLE_ALU     = 1'b0,
  parameter bit          TWO_CYCLE_COMPARE = 1'b0,
  parameter int unsigned REGINDEX_BITS     = 5,
  // Reset value of out_retired; only nonzero to exercise counter wrap-around.
  parameter logic [31:0] RETIRED_INIT      = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [REGINDEX_BITS-1:0] in_rd,
  input  logic [31:0]              reg_op1,
  input  logic [31:0]              reg_op2,
  input  logic [31:0]              alu_add_sub,
  input  logic [31:0]              alu_shl,
  input  logic [31:0]              alu_shr,
  input  logic                     alu_eq,
  input  logic                     alu_lts,
  input  logic                     alu_ltu,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REGINDEX_BITS-1:0] out_rd,
  output logic [31:0]              out_wdata,
  output logic                     out_wen,
  output logic                     out_branch_taken,
  output logic                     out_illegal,
  output logic [31:0]              out_retired
);

  state_e                   state_q;
  logic [3:0]               op_q;
  logic [REGINDEX_BITS-1:0] rd_q;
  logic                     cmp_q;

  logic [3:0]               mux_op;
  logic [REGINDEX_BITS-1:0] mux_rd;
  logic [31:0]              mux_wdata;
  logic                     mux_wen;
  logic                     mux_taken;
  logic                     mux_illegal;
  logic                     accept;
  logic                     handoff;

  // In WAIT_ALU the op was captured a cycle earlier; otherwise decode the incoming op.
  assign mux_op = (state_q == StWaitAlu) ? op_q : in_op;
  assign mux_rd = (state_q == StWaitAlu) ? rd_q : in_rd;

  assign out_valid = (state_q == StHold);
  assign in_ready  = ~reset & ((state_q == StIdle) | ((state_q == StHold) & out_ready));
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;

  alu_result_mux #(
    .REGINDEX_BITS(REGINDEX_BITS)
  ) u_mux (
    .op          (mux_op),
    .rd          (mux_rd),
    .reg_op1     (reg_op1),
    .reg_op2     (reg_op2),
    .alu_add_sub (alu_add_sub),
    .alu_shl     (alu_shl),
    .alu_shr     (alu_shr),
    .alu_eq      (alu_eq),
    .alu_lts     (alu_lts),
    .alu_ltu     (alu_ltu),
    .wdata       (mux_wdata),
    .wen         (mux_wen),
    .taken       (mux_taken),
    .illegal     (mux_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      op_q             <= '0;
      rd_q             <= '0;
      cmp_q            <= 1'b0;
      out_rd           <= '0;
      out_wdata        <= '0;
      out_wen          <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
      out_retired      <= RETIRED_INIT;
    end else begin
      if (handoff) out_retired <= out_retired + 32'd1;
      unique case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            op_q <= in_op;
            rd_q <= in_rd;
            if (TWO_CYCLE_ALU) begin
              state_q <= StWaitAlu;
            end else if (TWO_CYCLE_COMPARE && op_is_branch(in_op)) begin
              cmp_q   <= mux_taken;
              state_q <= StWaitCmp;
            end else begin
              out_rd           <= mux_rd;
              out_wdata        <= mux_wdata;
              out_wen          <= mux_wen;
              out_branch_taken <= mux_taken;
              out_illegal      <= mux_illegal;
              state_q          <= StHold;
            end
          end else if (handoff) begin
            state_q <= StIdle;
          end
        end
        StWaitAlu: begin
          if (TWO_CYCLE_COMPARE && op_is_branch(op_q)) begin
            cmp_q   <= mux_taken;
            state_q <= StWaitCmp;
          end else begin
            out_rd           <= mux_rd;
            out_wdata        <= mux_wdata;
            out_wen          <= mux_wen;
            out_branch_taken <= mux_taken;
            out_illegal      <= mux_illegal;
            state_q          <= StHold;
          end
        end
        StWaitCmp: begin
          // Only branch ops reach here, so the packet never writes a register.
          out_rd           <= rd_q;
          out_wdata        <= '0;
          out_wen          <= 1'b0;
          out_branch_taken <= cmp_q;
          out_illegal      <= 1'b0;
          state_q          <= StHold;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a single-cycle instance (a) and a two-cycle
// ALU/compare instance (b) with its retired counter starting at all-ones.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [31:0] reg_op1, reg_op2, alu_add_sub, alu_shl, alu_shr;
  logic        alu_eq, alu_lts, alu_ltu;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_wen_a, out_taken_a, out_illegal_a;
  logic [4:0]  out_rd_a;
  logic [31:0] out_wdata_a, out_retired_a;
  logic        in_ready_b, out_valid_b, out_wen_b, out_taken_b, out_illegal_b;
  logic [4:0]  out_rd_b;
  logic [31:0] out_wdata_b, out_retired_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .TWO_CYCLE_ALU     (1'b0),
    .TWO_CYCLE_COMPARE (1'b0),
    .REGINDEX_BITS     (5),
    .RETIRED_INIT      (32'h0)
  ) dut_a (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready_a),
    .in_op            (in_op),
    .in_rd            (in_rd),
    .reg_op1          (reg_op1),
    .reg_op2          (reg_op2),
    .alu_add_sub      (alu_add_sub),
    .alu_shl          (alu_shl),
    .alu_shr          (alu_shr),
    .alu_eq           (alu_eq),
    .alu_lts          (alu_lts),
    .alu_ltu          (alu_ltu),
    .out_valid        (out_valid_a),
    .out_ready        (out_ready),
    .out_rd           (out_rd_a),
    .out_wdata        (out_wdata_a),
    .out_wen          (out_wen_a),
    .out_branch_taken (out_taken_a),
    .out_illegal      (out_illegal_a),
    .out_retired      (out_retired_a)
  );

  alu_result_stage #(
    .TWO_CYCLE_ALU     (1'b1),
    .TWO_CYCLE_COMPARE (1'b1),
    .REGINDEX_BITS     (5),
    .RETIRED_INIT      (32'hFFFF_FFFF)
  ) dut_b (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready_b),
    .in_op            (in_op),
    .in_rd            (in_rd),
    .reg_op1          (reg_op1),
    .reg_op2          (reg_op2),
    .alu_add_sub      (alu_add_sub),
    .alu_shl          (alu_shl),
    .alu_shr          (alu_shr),
    .alu_eq           (alu_eq),
    .alu_lts          (alu_lts),
    .alu_ltu          (alu_ltu),
    .out_valid        (out_valid_b),
    .out_ready        (out_ready),
    .out_rd           (out_rd_b),
    .out_wdata        (out_wdata_b),
    .out_wen          (out_wen_b),
    .out_branch_taken (out_taken_b),
    .out_illegal      (out_illegal_b),
    .out_retired      (out_retired_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = 4'd0; in_rd = 5'd0;
    reg_op1 = '0; reg_op2 = '0; alu_add_sub = '0; alu_shl = '0; alu_shr = '0;
    alu_eq = 1'b0; alu_lts = 1'b0; alu_ltu = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (in_ready_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a);
    end
    n_cmp++;
    if ({out_valid_a, out_wen_a, out_taken_a, out_illegal_a} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {out_valid_a, out_wen_a, out_taken_a, out_illegal_a});
    end
    n_cmp++;
    if ({out_rd_a, out_wdata_a, out_retired_a} !== 69'd0) begin
      n_bad++;
      $display("FAIL reset_data: got rd %h wdata %h retired %h want 0",
               out_rd_a, out_wdata_a, out_retired_a);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (in_ready_a !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready_a);
    end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd5; alu_add_sub = 32'h1234; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid_a, out_wen_a, out_rd_a, out_wdata_a} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      n_bad++;
      $display("FAIL add_packet: got valid %b wen %b rd %0d wdata %h want 1 1 5 00001234",
               out_valid_a, out_wen_a, out_rd_a, out_wdata_a);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_retired_a !== 32'd1 || out_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL add_retire: got retired %0d valid %b want 1 0", out_retired_a, out_valid_a);
    end
  endtask

  task automatic test_branch();
    alu_add_sub = 32'hDEAD; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd10; in_rd = 5'd3; alu_lts = 1'b1; alu_eq = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid_a, out_taken_a, out_wen_a, out_wdata_a} !== {3'b110, 32'h0}) begin
      n_bad++;
      $display("FAIL blt_taken: got valid %b taken %b wen %b wdata %h want 1 1 0 0",
               out_valid_a, out_taken_a, out_wen_a, out_wdata_a);
    end
    in_op = 4'd9; alu_eq = 1'b1; alu_lts = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid_a, out_taken_a, out_wen_a, out_wdata_a} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL bne_not_taken: got valid %b taken %b wen %b wdata %h want 1 0 0 0",
               out_valid_a, out_taken_a, out_wen_a, out_wdata_a);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_retired_a !== 32'd3) begin
      n_bad++; $display("FAIL branch_retired: got %0d want 3", out_retired_a);
    end
  endtask

  task automatic test_edge_cases();
    out_ready = 1'b1; in_valid = 1'b1;
    in_op = 4'd2; in_rd = 5'd0; alu_lts = 1'b1; alu_ltu = 1'b0;
    tick();
    n_cmp++;
    if ({out_wen_a, out_wdata_a} !== {1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL slt_rd0: got wen %b wdata %h want 0 00000001", out_wen_a, out_wdata_a);
    end
    in_op = 4'd3; in_rd = 5'd4; alu_lts = 1'b0; alu_ltu = 1'b1;
    tick();
    n_cmp++;
    if ({out_wen_a, out_rd_a, out_wdata_a} !== {1'b1, 5'd4, 32'd1}) begin
      n_bad++;
      $display("FAIL sltu: got wen %b rd %0d wdata %h want 1 4 00000001",
               out_wen_a, out_rd_a, out_wdata_a);
    end
    in_op = 4'd1; in_rd = 5'd6; alu_shl = 32'hAAAA_0000;
    tick();
    n_cmp++;
    if ({out_wen_a, out_wdata_a} !== {1'b1, 32'hAAAA_0000}) begin
      n_bad++;
      $display("FAIL sll: got wen %b wdata %h want 1 aaaa0000", out_wen_a, out_wdata_a);
    end
    in_op = 4'd5; in_rd = 5'd7; alu_shr = 32'h0000_5555;
    tick();
    n_cmp++;
    if ({out_wen_a, out_wdata_a} !== {1'b1, 32'h0000_5555}) begin
      n_bad++;
      $display("FAIL srl: got wen %b wdata %h want 1 00005555", out_wen_a, out_wdata_a);
    end
    in_op = 4'd15; alu_eq = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid_a, out_illegal_a, out_wen_a, out_taken_a, out_wdata_a} !== {4'b1100, 32'h0})
    begin
      n_bad++;
      $display("FAIL illegal_op: got valid %b ill %b wen %b taken %b wdata %h want 1 1 0 0 0",
               out_valid_a, out_illegal_a, out_wen_a, out_taken_a, out_wdata_a);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    reg_op1 = 32'hF0F0_1234; reg_op2 = 32'h0FF0_5678;
    out_ready = 1'b1; in_valid = 1'b1;
    in_op = 4'd4; in_rd = 5'd1;
    tick();
    n_cmp++;
    if ({out_valid_a, out_rd_a, out_wdata_a} !== {1'b1, 5'd1, 32'hFF00_444C}) begin
      n_bad++;
      $display("FAIL b2b_xor: got valid %b rd %0d wdata %h want 1 1 ff00444c",
               out_valid_a, out_rd_a, out_wdata_a);
    end
    in_op = 4'd6; in_rd = 5'd2;
    tick();
    n_cmp++;
    if ({out_valid_a, out_rd_a, out_wdata_a} !== {1'b1, 5'd2, 32'hFFF0_567C}) begin
      n_bad++;
      $display("FAIL b2b_or: got valid %b rd %0d wdata %h want 1 2 fff0567c",
               out_valid_a, out_rd_a, out_wdata_a);
    end
    in_op = 4'd7; in_rd = 5'd3;
    tick();
    n_cmp++;
    if ({out_valid_a, out_rd_a, out_wdata_a} !== {1'b1, 5'd3, 32'h00F0_1230}) begin
      n_bad++;
      $display("FAIL b2b_and: got valid %b rd %0d wdata %h want 1 3 00f01230",
               out_valid_a, out_rd_a, out_wdata_a);
    end
    // Stall: a new op is offered but must not displace the held packet.
    out_ready = 1'b0; in_op = 4'd0; in_rd = 5'd9; alu_add_sub = 32'h1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready_a !== 1'b0) begin
        n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready_a);
      end
      tick();
      n_cmp++;
      if ({out_valid_a, out_rd_a, out_wdata_a} !== {1'b1, 5'd3, 32'h00F0_1230}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got valid %b rd %0d wdata %h want 1 3 00f01230",
                 i, out_valid_a, out_rd_a, out_wdata_a);
      end
    end
    n_cmp++;
    if (out_retired_a !== 32'd2) begin
      n_bad++; $display("FAIL b2b_retired: got %0d want 2", out_retired_a);
    end
    // Reset while holding: the packet is dropped without retiring.
    reset = 1'b1;
    tick();
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_retired_a !== 32'd0) begin
      n_bad++;
      $display("FAIL hold_reset: got valid %b retired %0d want 0 0", out_valid_a, out_retired_a);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_reset_after: got in_ready %b valid %b want 1 0",
               in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_two_cycle();
    reset_dut();
    in_valid = 1'b1; in_op = 4'd8; in_rd = 5'd9; alu_eq = 1'b1; out_ready = 1'b0;
    #1;
    n_cmp++;
    if (in_ready_b !== 1'b1 || out_retired_b !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL slow_idle: got in_ready %b retired %h want 1 ffffffff",
               in_ready_b, out_retired_b);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (in_ready_b !== 1'b0 || out_valid_b !== 1'b0) begin
        n_bad++;
        $display("FAIL slow_wait[%0d]: got in_ready %b valid %b want 0 0",
                 i, in_ready_b, out_valid_b);
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid_b, out_taken_b, out_wen_b, out_rd_b} !== {3'b110, 5'd9}) begin
      n_bad++;
      $display("FAIL slow_beq: got valid %b taken %b wen %b rd %0d want 1 1 0 9",
               out_valid_b, out_taken_b, out_wen_b, out_rd_b);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_retired_b !== 32'd0 || out_valid_b !== 1'b0) begin
      n_bad++;
      $display("FAIL retired_wrap: got retired %h valid %b want 00000000 0",
               out_retired_b, out_valid_b);
    end
    in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd1; alu_add_sub = 32'h55;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid_b !== 1'b0) begin
      n_bad++; $display("FAIL slow_add_wait: got valid %b want 0", out_valid_b);
    end
    tick();
    n_cmp++;
    if ({out_valid_b, out_wen_b, out_wdata_b} !== {2'b11, 32'h55}) begin
      n_bad++;
      $display("FAIL slow_add: got valid %b wen %b wdata %h want 1 1 00000055",
               out_valid_b, out_wen_b, out_wdata_b);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_retired_b !== 32'd1) begin
      n_bad++; $display("FAIL slow_retired: got %0d want 1", out_retired_b);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_edge_cases();
    test_back_to_back();
    test_two_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
